// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, BUSY, DONE)
//   port_sel_t      : requester select, CPU=0, IO=1
//   TIMEOUT_DEFAULT : BUSY cycles waited for memReady before aborting
//   WIDTH_DEFAULT   : address/data width
//   other_port()    : the requester that is not the given one
package mem_arbiter_pkg;

   localparam int TIMEOUT_DEFAULT = 15;
   localparam int WIDTH_DEFAULT   = 36;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_IO  = 1'b1
   } port_sel_t;

   function automatic port_sel_t other_port(input port_sel_t p);
      return (p == PORT_CPU) ? PORT_IO : PORT_CPU;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant decision (purely combinational).
//   req_cpu_i, req_io_i : pending requests
//   last_grant_i        : requester granted most recently
//   gnt_valid_o         : at least one request is pending
//   gnt_idx_o           : requester to grant; on a tie, the one not granted last
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic      req_cpu_i,
   input  logic      req_io_i,
   input  port_sel_t last_grant_i,
   output logic      gnt_valid_o,
   output port_sel_t gnt_idx_o
);

   always_comb begin
      gnt_valid_o = req_cpu_i | req_io_i;
      gnt_idx_o   = PORT_CPU;
      if (req_cpu_i && req_io_i) begin
         gnt_idx_o = other_port(last_grant_i);
      end else if (req_io_i) begin
         gnt_idx_o = PORT_IO;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU memory-stage port and an IO/loader port onto a single
// memory request channel, one transaction outstanding at a time.
//   clock, reset                      : rising-edge clock, async active-low reset
//   cpuReq/cpuWrite/cpuAddress/...    : CPU request; cpuReadData/cpuDone response
//   stallM                            : cpuReq AND NOT cpuDone
//   ioReq/ioWrite/ioAddress/...       : IO request; ioReadData/ioDone response
//   memValid/memWrite/memAddress/...  : memory request, held stable while BUSY
//   memReady, memReadData             : memory completion and read data
//   errorTimeout                      : sticky, set by any aborted transaction
//   dbgState                          : current FSM state for observation
//
// Handshake: a requester raises req with its operands and holds them until
// its Done pulse; the arbiter samples operands only at grant. On the memory
// side memValid stays high for the whole BUSY period and the transaction
// completes on the first cycle memReady is seen high (memReadData is taken in
// that same cycle); memReady outside BUSY has no effect.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cpuReq,
   input  logic             cpuWrite,
   input  logic [WIDTH-1:0] cpuAddress,
   input  logic [WIDTH-1:0] cpuWriteData,
   output logic [WIDTH-1:0] cpuReadData,
   output logic             cpuDone,
   output logic             stallM,
   input  logic             ioReq,
   input  logic             ioWrite,
   input  logic [WIDTH-1:0] ioAddress,
   input  logic [WIDTH-1:0] ioWriteData,
   output logic [WIDTH-1:0] ioReadData,
   output logic             ioDone,
   output logic             memValid,
   output logic             memWrite,
   output logic [WIDTH-1:0] memAddress,
   output logic [WIDTH-1:0] memWriteData,
   input  logic             memReady,
   input  logic [WIDTH-1:0] memReadData,
   output logic             errorTimeout,
   output arb_state_t       dbgState
);

   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t       state_q;
   port_sel_t        last_grant_q;
   port_sel_t        grant_q;
   logic [CW-1:0]    cnt_q;
   logic             mem_valid_q;
   logic             mem_write_q;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic [WIDTH-1:0] cpu_rdata_q;
   logic [WIDTH-1:0] io_rdata_q;
   logic             cpu_done_q;
   logic             io_done_q;
   logic             err_q;

   // Next grant, evaluated every cycle but only acted upon in IDLE.
   logic             gnt_valid_d;
   port_sel_t        gnt_sel_d;

   rr_arbiter2 u_rr (
      .req_cpu_i    (cpuReq),
      .req_io_i     (ioReq),
      .last_grant_i (last_grant_q),
      .gnt_valid_o  (gnt_valid_d),
      .gnt_idx_o    (gnt_sel_d)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= PORT_IO;   // makes the first tie go to the CPU
         grant_q      <= PORT_CPU;
         cnt_q        <= '0;
         mem_valid_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         io_rdata_q   <= '0;
         cpu_done_q   <= 1'b0;
         io_done_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // Done is a single-cycle pulse: raised on entry to DONE only.
         cpu_done_q <= 1'b0;
         io_done_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (gnt_valid_d) begin
                  grant_q      <= gnt_sel_d;
                  last_grant_q <= gnt_sel_d;
                  cnt_q        <= '0;
                  mem_valid_q  <= 1'b1;
                  if (gnt_sel_d == PORT_IO) begin
                     mem_write_q <= ioWrite;
                     mem_addr_q  <= ioAddress;
                     mem_wdata_q <= ioWriteData;
                  end else begin
                     mem_write_q <= cpuWrite;
                     mem_addr_q  <= cpuAddress;
                     mem_wdata_q <= cpuWriteData;
                  end
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (memReady || (cnt_q == CW'(TIMEOUT - 1))) begin
                  // Completion or abort: both leave BUSY and pulse Done.
                  if (memReady) begin
                     if (!mem_write_q) begin
                        if (grant_q == PORT_IO) io_rdata_q  <= memReadData;
                        else                    cpu_rdata_q <= memReadData;
                     end
                  end else begin
                     if (grant_q == PORT_IO) io_rdata_q  <= '0;
                     else                    cpu_rdata_q <= '0;
                     err_q <= 1'b1;
                  end
                  if (grant_q == PORT_IO) io_done_q  <= 1'b1;
                  else                    cpu_done_q <= 1'b1;
                  mem_valid_q <= 1'b0;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign memValid     = mem_valid_q;
   assign memWrite     = mem_write_q;
   assign memAddress   = mem_addr_q;
   assign memWriteData = mem_wdata_q;
   assign cpuReadData  = cpu_rdata_q;
   assign ioReadData   = io_rdata_q;
   assign cpuDone      = cpu_done_q;
   assign ioDone       = io_done_q;
   assign errorTimeout = err_q;
   assign dbgState     = state_q;
   assign stallM       = cpuReq & ~cpu_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random episodes of CPU/IO transactions, a memory
// responder with per-transaction latency, and a Done monitor that pops a
// transaction-level expected queue.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int W     = 36;
   localparam int TO    = 15;
   localparam int NEVER = 40;   // response delay that never arrives in time

   typedef struct {
      bit         io;
      bit         wr;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] mem_rdata;
      logic [W-1:0] rd_exp;
      int         delay;
      bit         abort;
      int         busy_len;
   } txn_t;

   // ---------------- clock / reset / DUT ----------------
   logic         clock, reset;
   logic         cpuReq, cpuWrite, ioReq, ioWrite;
   logic [W-1:0] cpuAddress, cpuWriteData, ioAddress, ioWriteData;
   logic [W-1:0] cpuReadData, ioReadData, memAddress, memWriteData, memReadData;
   logic         cpuDone, ioDone, stallM, memValid, memWrite, memReady, errorTimeout;
   arb_state_t   dbg_state;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   mem_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
      .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData), .cpuDone(cpuDone),
      .stallM(stallM),
      .ioReq(ioReq), .ioWrite(ioWrite), .ioAddress(ioAddress),
      .ioWriteData(ioWriteData), .ioReadData(ioReadData), .ioDone(ioDone),
      .memValid(memValid), .memWrite(memWrite), .memAddress(memAddress),
      .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData),
      .errorTimeout(errorTimeout), .dbgState(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   txn_t ep_cq[$];
   txn_t ep_iq[$];
   txn_t exp_mem_q[$];
   txn_t exp_done_q[$];

   port_sel_t    m_last;
   logic [W-1:0] pred_cpu_rd, pred_io_rd;
   logic [W-1:0] cpu_rd_exp, io_rd_exp;
   bit           err_exp;
   int           rise_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   function automatic txn_t mk_txn(input bit io, input bit wr, input logic [W-1:0] addr,
                                   input logic [W-1:0] wdata, input logic [W-1:0] mrd,
                                   input int delay);
      txn_t t;
      t.io = io; t.wr = wr; t.addr = addr; t.wdata = wdata; t.mem_rdata = mrd;
      t.delay = delay; t.rd_exp = '0; t.abort = 1'b0; t.busy_len = 0;
      return t;
   endfunction

   function automatic txn_t rand_txn(input bit io);
      int d;
      d = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 4));
      return mk_txn(io, 1'($urandom_range(0, 1)), rand_w(), rand_w(), rand_w(), d);
   endfunction

   // ---------------- driver ----------------
   task automatic drive_txn(input txn_t t, input bit solo);
      int n;
      int stall_n;
      bit got;
      int busy;
      busy = (t.delay >= TO) ? TO : t.delay + 1;
      @(posedge clock); #1;
      if (t.io) begin
         ioReq = 1'b1; ioWrite = t.wr; ioAddress = t.addr; ioWriteData = t.wdata;
      end else begin
         cpuReq = 1'b1; cpuWrite = t.wr; cpuAddress = t.addr; cpuWriteData = t.wdata;
      end
      #1;
      stall_n = int'(stallM);
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(posedge clock); #1;
         n++;
         got = t.io ? ioDone : cpuDone;
         if (!got) begin
            if (!t.io && stallM) stall_n++;
            // After the grant the arbiter must ignore operand changes.
            if (solo && memValid) begin
               if (t.io) begin
                  ioAddress = rand_w(); ioWriteData = rand_w(); ioWrite = 1'($urandom_range(0, 1));
               end else begin
                  cpuAddress = rand_w(); cpuWriteData = rand_w(); cpuWrite = 1'($urandom_range(0, 1));
               end
            end
         end
      end
      check(t.io ? "io_done_seen" : "cpu_done_seen", 64'(got), 64'd1);
      if (!t.io && got) check("cpu_stall_at_done", 64'(stallM), 64'd0);
      if (solo && !t.io && got) check("cpu_stall_cycles", 64'(stall_n), 64'(busy + 1));
      if (t.io) begin
         ioReq = 1'b0; ioAddress = rand_w(); ioWriteData = rand_w();
      end else begin
         cpuReq = 1'b0; cpuAddress = rand_w(); cpuWriteData = rand_w();
      end
   endtask

   // Predicts service order from the round-robin rule, pushes expectations,
   // then runs both requesters concurrently.
   task automatic run_episode();
      int ci;
      int ii;
      bit pick_io;
      bit solo;
      txn_t t;
      ci = 0;
      ii = 0;
      solo = (ep_cq.size() + ep_iq.size() == 1);
      while (ci < ep_cq.size() || ii < ep_iq.size()) begin
         if (ci < ep_cq.size() && ii < ep_iq.size()) pick_io = (m_last == PORT_CPU);
         else pick_io = (ii < ep_iq.size());
         if (pick_io) begin t = ep_iq[ii]; ii++; end
         else begin t = ep_cq[ci]; ci++; end
         m_last = pick_io ? PORT_IO : PORT_CPU;
         t.abort = (t.delay >= TO);
         t.busy_len = t.abort ? TO : t.delay + 1;
         if (t.abort) begin
            if (pick_io) pred_io_rd = '0; else pred_cpu_rd = '0;
         end else if (!t.wr) begin
            if (pick_io) pred_io_rd = t.mem_rdata; else pred_cpu_rd = t.mem_rdata;
         end
         t.rd_exp = pick_io ? pred_io_rd : pred_cpu_rd;
         exp_mem_q.push_back(t);
         exp_done_q.push_back(t);
      end
      fork
         begin
            foreach (ep_cq[i]) drive_txn(ep_cq[i], solo);
         end
         begin
            foreach (ep_iq[i]) drive_txn(ep_iq[i], solo);
         end
      join
      @(posedge clock); #1;
      ep_cq.delete();
      ep_iq.delete();
   endtask

   // ---------------- memory responder ----------------
   bit   in_txn = 1'b0;
   int   wcnt = 0;
   txn_t cur;

   initial begin
      memReady = 1'b0;
      memReadData = '0;
      forever begin
         @(posedge clock); #1;
         if (!reset) begin
            in_txn = 1'b0;
            memReady = 1'b0;
         end else begin
            if (in_txn && !memValid) in_txn = 1'b0;
            if (memValid && !in_txn) begin
               if (exp_mem_q.size() == 0) begin
                  check("mem_unexpected_valid", 64'(memValid), 64'd0);
               end else begin
                  cur = exp_mem_q.pop_front();
                  in_txn = 1'b1;
                  wcnt = 0;
                  rise_cyc = cyc;
               end
            end
            if (in_txn) begin
               check("mem_write", 64'(memWrite), 64'(cur.wr));
               check("mem_addr", 64'(memAddress), 64'(cur.addr));
               check("mem_wdata", 64'(memWriteData), 64'(cur.wdata));
               if (wcnt == cur.delay) begin
                  memReady = 1'b1;
                  memReadData = cur.mem_rdata;
               end else begin
                  memReady = 1'b0;
                  memReadData = rand_w();
               end
               wcnt++;
            end else begin
               // Noise outside BUSY; the arbiter must ignore it.
               memReady = 1'($urandom_range(0, 1));
               memReadData = rand_w();
            end
         end
      end
   end

   // ---------------- monitor ----------------
   txn_t mon_e;

   always @(negedge clock) begin
      if (reset) begin
         if (cpuDone || ioDone) begin
            check("single_done", 64'(cpuDone & ioDone), 64'd0);
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 64'({cpuDone, ioDone}), 64'd0);
            end else begin
               mon_e = exp_done_q.pop_front();
               check("done_port_io", 64'(ioDone), 64'(mon_e.io));
               check("done_latency", 64'(cyc - rise_cyc), 64'(mon_e.busy_len));
               if (mon_e.io) io_rd_exp = mon_e.rd_exp;
               else          cpu_rd_exp = mon_e.rd_exp;
               if (mon_e.abort) err_exp = 1'b1;
            end
         end
         check("cpu_read_data", 64'(cpuReadData), 64'(cpu_rd_exp));
         check("io_read_data", 64'(ioReadData), 64'(io_rd_exp));
         check("error_timeout", 64'(errorTimeout), 64'(err_exp));
      end
   end

   // ---------------- reset during BUSY ----------------
   task automatic reset_mid_busy();
      txn_t t;
      int n;
      t = mk_txn(1'b0, 1'b0, rand_w(), rand_w(), rand_w(), NEVER);
      exp_mem_q.push_back(t);
      @(posedge clock); #1;
      cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = t.addr; cpuWriteData = t.wdata;
      n = 0;
      while (!memValid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      check("rst_busy_reached", 64'(memValid), 64'd1);
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b0;
      cpuReq = 1'b0;
      err_exp = 1'b0; cpu_rd_exp = '0; io_rd_exp = '0;
      pred_cpu_rd = '0; pred_io_rd = '0; m_last = PORT_IO;
      #1;
      check("rst_async_memvalid", 64'(memValid), 64'd0);
      check("rst_async_cpudone", 64'(cpuDone), 64'd0);
      check("rst_async_err", 64'(errorTimeout), 64'd0);
      check("rst_async_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clock);
      @(negedge clock); #1;
      reset = 1'b1;
      repeat (4) begin
         @(posedge clock); #1;
         check("rst_after_state", 64'(dbg_state), 64'(ST_IDLE));
         check("rst_after_no_done", 64'({cpuDone, ioDone}), 64'd0);
         check("rst_after_memvalid", 64'(memValid), 64'd0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #600000;
      $display("FAIL watchdog: got=running want=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int nc;
      int ni;
      reset = 1'b0;
      cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddress = '0; cpuWriteData = '0;
      ioReq = 1'b0; ioWrite = 1'b0; ioAddress = '0; ioWriteData = '0;
      m_last = PORT_IO;
      pred_cpu_rd = '0; pred_io_rd = '0;
      cpu_rd_exp = '0; io_rd_exp = '0; err_exp = 1'b0;

      #12;
      check("reset_memvalid", 64'(memValid), 64'd0);
      check("reset_memwrite", 64'(memWrite), 64'd0);
      check("reset_memaddr", 64'(memAddress), 64'd0);
      check("reset_memwdata", 64'(memWriteData), 64'd0);
      check("reset_cpu_rd", 64'(cpuReadData), 64'd0);
      check("reset_io_rd", 64'(ioReadData), 64'd0);
      check("reset_dones", 64'({cpuDone, ioDone}), 64'd0);
      check("reset_err", 64'(errorTimeout), 64'd0);
      check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clock); #1;
      reset = 1'b1;
      repeat (2) @(posedge clock);

      // First tie after reset: CPU write 2 to 7, IO read of 9.
      ep_cq.push_back(mk_txn(1'b0, 1'b1, 36'd7, 36'd2, rand_w(), 0));
      ep_iq.push_back(mk_txn(1'b1, 1'b0, 36'd9, rand_w(), rand_w(), 1));
      run_episode();

      // CPU read of address 5 returning 13 with memReady already high.
      ep_cq.push_back(mk_txn(1'b0, 1'b0, 36'd5, rand_w(), 36'd13, 0));
      run_episode();

      // Both ports continuously busy for four transactions.
      for (int i = 0; i < 2; i++) begin
         ep_cq.push_back(mk_txn(1'b0, 1'($urandom_range(0, 1)), rand_w(), rand_w(), rand_w(), int'($urandom_range(0, 3))));
         ep_iq.push_back(mk_txn(1'b1, 1'($urandom_range(0, 1)), rand_w(), rand_w(), rand_w(), int'($urandom_range(0, 3))));
      end
      run_episode();

      // memReady never arrives: abort.
      ep_cq.push_back(mk_txn(1'b0, 1'b0, rand_w(), rand_w(), rand_w(), NEVER));
      run_episode();

      // memReady delayed 3 cycles with operands changing after grant.
      ep_cq.push_back(mk_txn(1'b0, 1'b0, rand_w(), rand_w(), rand_w(), 3));
      run_episode();

      for (int e = 0; e < 40; e++) begin
         nc = int'($urandom_range(0, 2));
         ni = int'($urandom_range(0, 2));
         if (nc == 0 && ni == 0) nc = 1;
         for (int k = 0; k < nc; k++) ep_cq.push_back(rand_txn(1'b0));
         for (int k = 0; k < ni; k++) ep_iq.push_back(rand_txn(1'b1));
         run_episode();
      end

      reset_mid_busy();

      for (int e = 0; e < 10; e++) begin
         nc = int'($urandom_range(0, 2));
         ni = int'($urandom_range(0, 2));
         if (nc == 0 && ni == 0) ni = 1;
         for (int k = 0; k < nc; k++) ep_cq.push_back(rand_txn(1'b0));
         for (int k = 0; k < ni; k++) ep_iq.push_back(rand_txn(1'b1));
         run_episode();
      end

      repeat (3) @(posedge clock);
      check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
      check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 36, data and address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum BUSY cycles spent waiting for memReady before abort.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-005 cpuReq, cpuWrite  in  1 each  CPU memory-stage request and write select.
REQ-006 cpuAddress, cpuWriteData  in  WIDTH each  CPU address and store data.
REQ-007 cpuReadData  out  WIDTH  CPU load data; cpuDone  out  1  one-cycle completion pulse.
REQ-008 stallM  out  1  pipeline stall, equal to cpuReq AND NOT cpuDone.
REQ-009 ioReq, ioWrite  in  1 each; ioAddress, ioWriteData  in  WIDTH each  IO/loader port request.
REQ-010 ioReadData  out  WIDTH; ioDone  out  1  IO-port equivalents of the CPU response.
REQ-011 memValid, memWrite  out  1 each; memAddress, memWriteData  out  WIDTH each  memory request.
REQ-012 memReady  in  1  memory acceptance/completion; memReadData  in  WIDTH  read data, valid with memReady.
REQ-013 errorTimeout  out  1  sticky flag, set on any aborted transaction.

Function
REQ-014 FSM states IDLE, BUSY and DONE; one transaction is outstanding at a time.
REQ-015 IDLE with no request: remain in IDLE; memValid is 0.
REQ-016 IDLE with exactly one request pending: grant that requester, latch its write flag, address and data, go to BUSY.
REQ-017 IDLE with both requests pending: grant the requester not granted last (round robin); the first tie after reset goes to the CPU.
REQ-018 lastGrant updates only on a grant.
REQ-019 BUSY: memValid is 1; memWrite, memAddress and memWriteData hold the latched values, stable until exit.
REQ-020 BUSY with memReady=1: register memReadData into the granted port's readData (reads only; writes leave readData unchanged), then go to DONE.
REQ-021 BUSY wait counter: cleared on entry and incremented each cycle memReady=0.
REQ-022 Timeout abort: on the TIMEOUT-th cycle with memReady=0, go to DONE, write 0 to the granted port's readData, and set errorTimeout.
REQ-023 DONE lasts exactly one cycle: pulse the granted port's Done, then return to IDLE; a new grant is possible in the following cycle.
REQ-024 Minimum latency with memReady already 1: req seen in IDLE at cycle N, memValid at N+1, Done at N+2.
REQ-025 Requesters hold req and operands until their Done; the arbiter ignores operand changes after the grant.
REQ-026 A req deasserted mid-transaction does not cancel it; the transaction completes and Done still pulses.
REQ-027 memReady while not in BUSY is ignored.
REQ-028 The non-granted port's Done stays 0; its readData holds its previous value.

Reset
REQ-029 On reset=0, asynchronously:
- state=IDLE, lastGrant=IO (so the first tie goes to the CPU), counter=0;
- memValid=0, memWrite=0, memAddress=0, memWriteData=0;
- cpuReadData=0, ioReadData=0, cpuDone=0, ioDone=0, errorTimeout=0.
REQ-030 Reset during BUSY abandons the transaction with no Done pulse; errorTimeout is cleared only by reset.

Structure
REQ-031 The FSM state enum, port-select encoding (CPU=0, IO=1) and TIMEOUT default live in the shared CPU package.
REQ-032 The round-robin grant decision is one sub-module, rr_arbiter2 (inputs: two requests and lastGrant; outputs: grant valid and grant index); everything else is in mem_arbiter.

Verification
REQ-033 CPU read: cpuReq=1, cpuAddress=5, memReady=1, memReadData=13 -> memValid at +1, cpuDone and cpuReadData=13 at +2, stallM high for 2 cycles.
REQ-034 Simultaneous requests after reset, CPU write 2 to address 7 and IO read of address 9 -> CPU served first with memWrite=1, memWriteData=2; then IO served with ioDone; ioReadData equals memReadData.
REQ-035 Both ports requesting continuously for 4 transactions -> grants alternate CPU, IO, CPU, IO.
REQ-036 memReady held 0 -> abort after 15 BUSY cycles, cpuDone pulses with cpuReadData=0, errorTimeout=1 and stays 1 through later successful transactions.
REQ-037 memReady delayed 3 cycles -> memAddress/memWriteData stable all 4 BUSY cycles despite cpuAddress changing; Done at req+5.
REQ-038 reset=0 asserted in BUSY -> memValid=0 immediately, no Done pulse, FSM in IDLE after release.
